// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial stage feeding a single-bit detector input.
// Accepts WIDTH-bit words over valid/ready and emits one bit per clock,
// supporting gapless back-to-back words. All outputs are registered.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  // Counter is at least one bit wide so WIDTH=1 still has a legal vector.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic dout_q, dout_d;
  logic dv_q, dv_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic last_bit;
  logic load_fire;
  logic head_d;

  // The cycle presenting the final bit of a word is also the cycle that may
  // accept the next word, which is what makes back-to-back streaming gapless.
  assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
  assign load_ready = (state_q == IDLE) || last_bit;
  assign load_fire  = load_valid && load_ready;

  // Shift direction and the bit presented on dout depend on the bit order.
  // Vacated positions fill with zero; a one-bit word simply empties.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sreg_shifted = 1'b0;
      assign head_d       = sreg_d[0];
    end else if (MSB_FIRST) begin : g_msb
      assign sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
      assign head_d       = sreg_d[WIDTH-1];
    end else begin : g_lsb
      assign sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
      assign head_d       = sreg_d[0];
    end
  endgenerate

  // Next-state logic: load from IDLE, shift while bits remain, reload or
  // retire on the last bit.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (load_fire) begin
          state_d = SHIFT;
          sreg_d  = data_in;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          sreg_d = sreg_shifted;
          cnt_d  = cnt_q + CNT_W'(1);
        end else if (load_fire) begin
          sreg_d = data_in;
          cnt_d  = '0;
        end else begin
          // Clearing the shift register keeps dout at 0 while idle.
          state_d = IDLE;
          sreg_d  = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        sreg_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next-values are derived from the next state so the ports come
  // straight from flops and line up with the bit being shifted out.
  always_comb begin
    dv_d   = (state_d == SHIFT);
    busy_d = (state_d == SHIFT);
    dout_d = (state_d == SHIFT) && head_d;
    done_d = (state_d == SHIFT) && (cnt_d == LAST_CNT);
  end

  // State and output registers with synchronous active-low reset; a reset
  // mid-word drops the word entirely.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
